// File: rtl/gt_pwm_pkg.sv
// Shared definitions for the multi-channel PWM: compare modes, legal
// parameter ranges and the counter bit-reversal helper.
package gt_pwm_pkg;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_BITREV = 1'b1;

  localparam int PWMBITS_MIN = 2;
  localparam int PWMBITS_MAX = 16;
  localparam int NCH_MIN     = 1;
  localparam int NCH_MAX     = 8;
  localparam int PREDIV_MIN  = 1;
  localparam int PREDIV_MAX  = 256;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [15:0] bit_rev(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) r[4'(i)] = v[4'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/gt_pwm_multi_if.sv
// Control/observation bundle of gt_pwm_multi: threshold writes, clear,
// compare mode in; PWM outputs and period tick out.
interface gt_pwm_multi_if #(
  parameter int PWMBITS = 8,
  parameter int NCH     = 2
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic               WR_EN;
  logic [CHW-1:0]     WR_CH;
  logic [PWMBITS-1:0] WR_DATA;
  logic               CLR;
  logic               MODE;
  logic [NCH-1:0]     PWM;
  logic               PERIOD_TICK;

  modport master (
    output WR_EN, WR_CH, WR_DATA, CLR, MODE,
    input  PWM, PERIOD_TICK
  );

  modport slave (
    input  WR_EN, WR_CH, WR_DATA, CLR, MODE,
    output PWM, PERIOD_TICK
  );
endinterface

// File: rtl/gt_pwm_chan.sv
// One PWM channel: shadow threshold written any time, active threshold
// loaded at the period wrap, registered compare output.
module gt_pwm_chan #(
  parameter int PWMBITS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [PWMBITS-1:0] wr_data_i,
  input  logic               clr_i,
  input  logic               wrap_i,
  input  logic [PWMBITS-1:0] cmp_i,
  output logic               pwm_o
);

  logic [PWMBITS-1:0] shadow_q;
  logic [PWMBITS-1:0] active_q;
  logic               pwm_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else if (clr_i) begin
      // Forcing the output low here keeps the old active value from
      // leaking out for one more cycle after the clear.
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (wr_en_i) shadow_q <= wr_data_i;
      if (wrap_i)  active_q <= shadow_q;
      pwm_q <= (cmp_i < active_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/gt_pwm_multi.sv
// Multi-channel PWM generator: shared prescaler and period counter,
// NCH double-buffered threshold channels, period-start tick.
module gt_pwm_multi
  import gt_pwm_pkg::*;
#(
  parameter int PWMBITS = 8,
  parameter int NCH     = 2,
  parameter int PREDIV  = 1
) (
  input  logic           CLK,
  input  logic           RST,
  gt_pwm_multi_if.slave  bus
);

  localparam int PCW = (PREDIV > 1) ? $clog2(PREDIV) : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  if (PWMBITS < PWMBITS_MIN || PWMBITS > PWMBITS_MAX) begin : g_bad_pwmbits
    $error("gt_pwm_multi: PWMBITS out of range");
  end
  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("gt_pwm_multi: NCH out of range");
  end
  if (PREDIV < PREDIV_MIN || PREDIV > PREDIV_MAX) begin : g_bad_prediv
    $error("gt_pwm_multi: PREDIV out of range");
  end

  logic [PCW-1:0]     pc_q, pc_d;
  logic [PWMBITS-1:0] cnt_q, cnt_d;
  logic [PWMBITS-1:0] cmp;
  logic               mode_act_q;
  logic               tick_q;
  logic               step;
  logic               wrap;
  logic [NCH-1:0]     pwm;

  assign step = (pc_q == PCW'(PREDIV - 1));
  assign wrap = step && (&cnt_q);
  assign pc_d  = step ? '0 : pc_q + PCW'(1);
  assign cnt_d = step ? cnt_q + PWMBITS'(1) : cnt_q;
  assign cmp   = (mode_act_q == MODE_BITREV) ?
                 PWMBITS'(bit_rev(16'(cnt_q), PWMBITS)) : cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= '0;
      cnt_q      <= '0;
      mode_act_q <= MODE_BITREV;
      tick_q     <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      tick_q <= wrap;
      // Mode only switches on a period boundary so a period never mixes modes.
      if (wrap) mode_act_q <= bus.MODE;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    gt_pwm_chan #(.PWMBITS(PWMBITS)) u_chan (
      .clk_i     (CLK),
      .rst_i     (RST),
      .wr_en_i   (bus.WR_EN && (bus.WR_CH == CHW'(i))),
      .wr_data_i (bus.WR_DATA),
      .clr_i     (bus.CLR),
      .wrap_i    (wrap),
      .cmp_i     (cmp),
      .pwm_o     (pwm[i])
    );
  end

  assign bus.PWM         = pwm;
  assign bus.PERIOD_TICK = tick_q;

endmodule

// File: tb/tb_gt_pwm_multi.sv
// Scoreboard bench: instance A (8 bit, 2 ch, PREDIV 1) and instance B
// (8 bit, 3 ch, PREDIV 4) with per-period statistics compared to queued expectations.
module tb_gt_pwm_multi;

  localparam int DC = -99;

  typedef struct {
    int per, hi0, hi1, hi2, first0, last0, alt1, len;
  } exp_t;

  typedef struct {
    int hi0, hi1, hi2, first0, last0, alt1, len;
  } stat_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  gt_pwm_multi_if #(.PWMBITS(8), .NCH(2)) bus_a ();
  gt_pwm_multi_if #(.PWMBITS(8), .NCH(3)) bus_b ();

  gt_pwm_multi #(.PWMBITS(8), .NCH(2), .PREDIV(1)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
  gt_pwm_multi #(.PWMBITS(8), .NCH(3), .PREDIV(4)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

  int    n_assert = 0;
  int    n_fail   = 0;
  exp_t  qa[$];
  exp_t  qb[$];
  int    ticks_a = 0, cyc_a = 0, ticks_b = 0, cyc_b = 0;
  stat_t st_a, st_b;

  function automatic void chk(string name, int act, int req);
    if (req == DC) return;
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic stat_t fresh();
    stat_t s;
    s.hi0 = 0; s.hi1 = 0; s.hi2 = 0;
    s.first0 = -1; s.last0 = -1; s.alt1 = 1; s.len = 0;
    return s;
  endfunction

  function automatic void acc(inout stat_t s, input int pos, input logic [2:0] p);
    if (p[0]) begin
      s.hi0++;
      if (s.first0 < 0) s.first0 = pos;
      s.last0 = pos;
    end
    if (p[1]) s.hi1++;
    if (p[2]) s.hi2++;
    if (p[1] != ((pos % 2) == 0)) s.alt1 = 0;
    s.len++;
  endfunction

  function automatic exp_t mk(int per, int hi0, int hi1, int hi2, int first0,
                              int last0, int alt1, int len);
    exp_t e;
    e.per = per; e.hi0 = hi0; e.hi1 = hi1; e.hi2 = hi2;
    e.first0 = first0; e.last0 = last0; e.alt1 = alt1; e.len = len;
    return e;
  endfunction

  function automatic void cmp_exp(string tag, exp_t e, stat_t s);
    chk($sformatf("%s.w%0d.hi0", tag, e.per), s.hi0, e.hi0);
    chk($sformatf("%s.w%0d.hi1", tag, e.per), s.hi1, e.hi1);
    chk($sformatf("%s.w%0d.hi2", tag, e.per), s.hi2, e.hi2);
    chk($sformatf("%s.w%0d.first0", tag, e.per), s.first0, e.first0);
    chk($sformatf("%s.w%0d.last0", tag, e.per), s.last0, e.last0);
    chk($sformatf("%s.w%0d.alt1", tag, e.per), s.alt1, e.alt1);
    chk($sformatf("%s.w%0d.len", tag, e.per), s.len, e.len);
  endfunction

  // Monitor A: a window runs from the cycle after a tick through the next
  // tick cycle, so position k holds the output for count k.
  always begin
    @(posedge CLK); #1;
    if (RST) begin
      ticks_a = 0; cyc_a = 0; st_a = fresh();
    end else begin
      cyc_a++;
      if (ticks_a > 0) acc(st_a, st_a.len, {1'b0, bus_a.PWM});
      if (bus_a.PERIOD_TICK) begin
        if (ticks_a == 0) chk("A.first_tick_cycle", cyc_a, 256);
        else if (qa.size() > 0 && qa[0].per == ticks_a) cmp_exp("A", qa.pop_front(), st_a);
        ticks_a++;
        st_a = fresh();
      end
    end
  end

  always begin
    @(posedge CLK); #1;
    if (RST) begin
      ticks_b = 0; cyc_b = 0; st_b = fresh();
    end else begin
      cyc_b++;
      if (ticks_b > 0) acc(st_b, st_b.len, bus_b.PWM);
      if (bus_b.PERIOD_TICK) begin
        if (ticks_b == 0) chk("B.first_tick_cycle", cyc_b, 1024);
        else if (qb.size() > 0 && qb[0].per == ticks_b) cmp_exp("B", qb.pop_front(), st_b);
        ticks_b++;
        st_b = fresh();
      end
    end
  end

  task automatic write_a(input int ch, input int data);
    @(negedge CLK);
    bus_a.WR_EN = 1'b1; bus_a.WR_CH = 1'(ch); bus_a.WR_DATA = 8'(data);
    @(negedge CLK);
    bus_a.WR_EN = 1'b0;
  endtask

  task automatic write_b(input int ch, input int data);
    @(negedge CLK);
    bus_b.WR_EN = 1'b1; bus_b.WR_CH = 2'(ch); bus_b.WR_DATA = 8'(data);
    @(negedge CLK);
    bus_b.WR_EN = 1'b0;
  endtask

  task automatic wait_a(input int n);
    int b;
    b = 0;
    while (ticks_a < n && b < 2000) begin @(negedge CLK); b++; end
    if (ticks_a < n) begin
      n_assert++; n_fail++;
      $display("FAIL A.wait_tick%0d: timed out with %0d ticks", n, ticks_a);
    end
  endtask

  task automatic wait_b(input int n);
    int b;
    b = 0;
    while (ticks_b < n && b < 6000) begin @(negedge CLK); b++; end
    if (ticks_b < n) begin
      n_assert++; n_fail++;
      $display("FAIL B.wait_tick%0d: timed out with %0d ticks", n, ticks_b);
    end
  endtask

  initial begin
    bus_a.WR_EN = 1'b0; bus_a.WR_CH = '0; bus_a.WR_DATA = '0; bus_a.CLR = 1'b0; bus_a.MODE = 1'b0;
    bus_b.WR_EN = 1'b0; bus_b.WR_CH = '0; bus_b.WR_DATA = '0; bus_b.CLR = 1'b0; bus_b.MODE = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("A.reset_pwm", int'(bus_a.PWM), 0);
    chk("A.reset_tick", int'(bus_a.PERIOD_TICK), 0);
    chk("B.reset_pwm", int'(bus_b.PWM), 0);
    chk("B.reset_tick", int'(bus_b.PERIOD_TICK), 0);
    RST = 1'b0;

    fork
      begin
        // Linear ch0=0x40: counts 0..63 high, ch1 idle.
        write_a(0, 8'h40);
        qa.push_back(mk(1, 64, 0, DC, 0, 63, DC, 256));
        qa.push_back(mk(2, 64, 0, DC, 0, 63, DC, 256));
        wait_a(2);
        // Bit-reversed: ch1=0x80 alternates, ch0=0x40 high every 4th count.
        bus_a.MODE = 1'b1;
        write_a(1, 8'h80);
        qa.push_back(mk(3, 64, 128, DC, 0, 252, 1, 256));
        wait_a(3);
        bus_a.MODE = 1'b0;
        write_a(0, 8'h20);
        qa.push_back(mk(4, 32, 128, DC, 0, 31, 0, 256));
        qa.push_back(mk(5, 32, 128, DC, 0, 31, DC, 256));
        qa.push_back(mk(6, 16, 128, DC, 0, 15, DC, 256));
        wait_a(4);
        // Write 0x10 in the wrap cycle (count 255): takes effect one period late.
        repeat (255) @(negedge CLK);
        bus_a.WR_EN = 1'b1; bus_a.WR_CH = 1'b0; bus_a.WR_DATA = 8'h10;
        @(negedge CLK);
        bus_a.WR_EN = 1'b0;
        wait_a(6);
        write_a(0, 8'hFF);
        qa.push_back(mk(7, 48, 48, DC, 0, 47, DC, 256));
        qa.push_back(mk(8, 0, 0, DC, -1, -1, DC, 256));
        qa.push_back(mk(9, 0, 0, DC, -1, -1, DC, 256));
        wait_a(7);
        // CLR with a competing write at count 0x30.
        repeat (48) @(negedge CLK);
        bus_a.CLR = 1'b1;
        bus_a.WR_EN = 1'b1; bus_a.WR_CH = 1'b0; bus_a.WR_DATA = 8'h55;
        @(negedge CLK);
        bus_a.CLR = 1'b0; bus_a.WR_EN = 1'b0;
        wait_a(10);
      end
      begin
        write_b(0, 8'h40);
        qb.push_back(mk(1, 256, 0, 0, 0, 255, DC, 1024));
        wait_b(1);
        // Out-of-range channel index must change nothing.
        write_b(3, 8'hFF);
        qb.push_back(mk(2, 256, 0, 0, 0, 255, DC, 1024));
        qb.push_back(mk(3, 256, 0, 0, 0, 255, DC, 1024));
        wait_b(4);
      end
    join

    chk("A.pending_expectations", qa.size(), 0);
    chk("B.pending_expectations", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gt_pwm_multi.md
GT_PWM_MULTI -- requirements
Module: gt_pwm_multi

Interface
REQ-001 SHALL have parameter PWMBITS, default 8, counter and threshold width (2..16).
REQ-002 SHALL have parameter NCH, default 2, number of PWM channels (1..8).
REQ-003 SHALL have parameter PREDIV, default 1, clock divisor per counter step (1..256).
REQ-004 SHALL have port CLK  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port WR_EN  in  1  single-cycle threshold write strobe.
REQ-007 SHALL have port WR_CH  in  max(1,clog2(NCH))  target channel index.
REQ-008 SHALL have port WR_DATA  in  PWMBITS  threshold value.
REQ-009 SHALL have port CLR  in  1  clear strobe: zero all thresholds immediately.
REQ-010 SHALL have port MODE  in  1  compare mode: 1 = bit-reversed counter, 0 = linear.
REQ-011 SHALL have port PWM  out  NCH  registered PWM outputs.
REQ-012 SHALL have port PERIOD_TICK  out  1  one-cycle pulse at each period start.

Function
REQ-013 SHALL keep prescaler pc counting 0..PREDIV-1; step = (pc == PREDIV-1); pc wraps to 0 on step; PREDIV=1 gives step every cycle.
REQ-014 SHALL advance a PWMBITS counter cnt by 1 on each step, modulo 2^PWMBITS.
REQ-015 SHALL define wrap = step && cnt == all-ones; period = 2^PWMBITS*PREDIV CLK cycles.
REQ-016 SHALL hold per channel a shadow and an active threshold register.
REQ-017 SHALL load shadow[WR_CH] <= WR_DATA when WR_EN and WR_CH < NCH; WR_CH >= NCH ignored, no state change.
REQ-018 SHALL copy all shadows to actives simultaneously on wrap, and latch MODE into mode_act on wrap only.
REQ-019 SHALL, on WR_EN coinciding with wrap, load active with the old shadow; new value takes effect at the following wrap.
REQ-020 SHALL compute cmp = bit-reverse(cnt) when mode_act=1, else cnt.
REQ-021 SHALL register PWM[i] <= (cmp < active[i]) every CLK; output lags cnt by exactly one cycle.
REQ-022 SHALL give duty active/2^PWMBITS; threshold 0 = constant low; all-ones = high all but one count; no 100% duty.
REQ-023 SHALL register PERIOD_TICK <= wrap, high exactly one cycle, in the cycle cnt first reads 0.
REQ-024 SHALL, on CLR, zero all shadows and actives in the same edge; PWM low from the next cycle; cnt, pc, mode_act unaffected.
REQ-025 SHALL give CLR priority over WR_EN and over the wrap copy in the same cycle.
REQ-026 SHALL ignore MODE changes mid-period; no output glitch other than the threshold effect at wrap.

Reset
REQ-027 SHALL on RST clear cnt, pc, all shadows and actives to 0, set mode_act to 1, and drive PWM = 0 and PERIOD_TICK = 0 on the next edge.
REQ-028 SHALL give RST priority over CLR, WR_EN, and wrap; RST mid-period restarts the period from cnt = 0.
REQ-029 SHALL emit the first PERIOD_TICK after reset exactly one period after RST deasserts.

Structure
REQ-030 SHALL place in shared package gt_pwm_pkg: bit-reverse function, mode constants MODE_LINEAR = 0 and MODE_BITREV = 1, and legal parameter bounds.
REQ-031 SHALL implement per-channel shadow, active, and comparator logic as sub-module gt_pwm_chan, generated NCH times; prescaler, counter, and PERIOD_TICK stay in the top.
REQ-032 SHALL reject illegal parameters at elaboration.

Verification (PWMBITS=8, NCH=2, PREDIV=1 unless stated)
REQ-033 SHALL check: RST; MODE=0; write ch0=0x40 -> after the next PERIOD_TICK, PWM[0] high for counts 0..63, i.e. 64 contiguous cycles per 256; PWM[1] stays 0.
REQ-034 SHALL check: MODE=1; ch1=0x80 -> PWM[1] alternates 1,0,1,0 every cycle across the whole period.
REQ-035 SHALL check: active ch0=0x20; write 0x10 in the wrap cycle -> next period 32 high counts, the one after 16.
REQ-036 SHALL check: WR_CH=2, WR_DATA=0xFF -> no register changes; PWM[1:0] unchanged over 2 periods.
REQ-037 SHALL check: active ch0=0xFF; pulse CLR at cnt=0x30 together with WR_EN ch0=0x55 -> PWM[0]=0 from the next cycle; shadow 0, so output stays low after the wrap.
REQ-038 SHALL check: PREDIV=4 -> PERIOD_TICK spacing exactly 1024 cycles; ch0=0x40 in linear mode gives 256 high cycles per period.
